// File: rtl/xfer_buf_pkg.sv
// Shared sizing, job-direction codes, FSM states and error-bit positions
// for the host transfer buffer slot scheduler.
package xfer_buf_pkg;

    localparam int MAX_BUFQ_DEPTH = 4;
    localparam int UNIT_BUF_BY_4B = 1024;
    localparam int SLOT_BYTES     = UNIT_BUF_BY_4B * 4;
    localparam int HDATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH  = 32;

    localparam int SLOT_W    = 3;
    localparam int CNT_W     = 4;
    localparam int FETCH_MAX = 15;

    localparam logic JOB_RX_DRAIN = 1'b0;
    localparam logic JOB_TX_FILL  = 1'b1;

    localparam int ERR_RX_OVF    = 0;
    localparam int ERR_TX_UNF    = 1;
    localparam int ERR_SPUR_DONE = 2;
    localparam int ERR_W         = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_t;

    function automatic logic [SLOT_W-1:0] slot_wrap_inc(input logic [SLOT_W-1:0] p);
        return (p == SLOT_W'(MAX_BUFQ_DEPTH - 1)) ? '0 : p + SLOT_W'(1);
    endfunction

endpackage

// File: rtl/xfer_slot_ring.sv
// One slot ring: wrap-around job pointer, TBM address counter, free-slot
// counter and a second occupancy counter whose meaning is set by the parent.
module xfer_slot_ring
    import xfer_buf_pkg::*;
(
    input  logic                     clock_host,
    input  logic                     reset,
    input  logic                     load_base,
    input  logic [ADDRESS_WIDTH-1:0] cfg_base,
    input  logic                     advance,
    input  logic                     free_inc,
    input  logic                     free_dec,
    input  logic                     aux_inc,
    input  logic                     aux_dec,
    output logic [SLOT_W-1:0]        ptr,
    output logic [ADDRESS_WIDTH-1:0] addr,
    output logic [CNT_W-1:0]         free_cnt,
    output logic                     aux_nonzero
);

    logic [SLOT_W-1:0]        ptr_reg;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [CNT_W-1:0]         free_reg;
    logic [CNT_W-1:0]         free_next;
    logic [CNT_W-1:0]         aux_reg;
    logic [CNT_W-1:0]         aux_next;
    logic                     aux_nz_reg;

    // Increments and decrements landing in the same cycle cancel out.
    always_comb begin
        free_next = free_reg + CNT_W'(free_inc) - CNT_W'(free_dec);
        aux_next  = aux_reg + CNT_W'(aux_inc) - CNT_W'(aux_dec);
    end

    always_ff @(posedge clock_host or posedge reset) begin
        if (reset) begin
            ptr_reg    <= '0;
            addr_reg   <= cfg_base;
            free_reg   <= CNT_W'(MAX_BUFQ_DEPTH);
            aux_reg    <= '0;
            aux_nz_reg <= 1'b0;
        end else begin
            free_reg   <= free_next;
            aux_reg    <= aux_next;
            aux_nz_reg <= (aux_next != '0);
            if (advance) begin
                ptr_reg <= slot_wrap_inc(ptr_reg);
            end
            if (load_base) begin
                addr_reg <= cfg_base;
            end else if (advance) begin
                addr_reg <= addr_reg + ADDRESS_WIDTH'(SLOT_BYTES);
            end
        end
    end

    assign ptr         = ptr_reg;
    assign addr        = addr_reg;
    assign free_cnt    = free_reg;
    assign aux_nonzero = aux_nz_reg;

endmodule

// File: rtl/xfer_slot_scheduler.sv
// Round-robin sequencer issuing RX drain / TX fill jobs to the memory-transfer
// engine, tracking slot occupancy of both host buffer rings.
module xfer_slot_scheduler
    import xfer_buf_pkg::*;
(
    input  logic                     clock_host,
    input  logic                     reset,
    input  logic                     sched_enable,
    input  logic [ADDRESS_WIDTH-1:0] cfg_rx_base,
    input  logic [ADDRESS_WIDTH-1:0] cfg_tx_base,
    input  logic                     rx_slot_filled,
    input  logic                     tx_slot_drained,
    input  logic                     tx_fetch_req,
    output logic                     job_valid,
    input  logic                     job_ready,
    output logic                     job_dir,
    output logic [2:0]               job_slot,
    output logic [ADDRESS_WIDTH-1:0] job_addr,
    input  logic                     job_done,
    output logic [3:0]               rx_anum,
    output logic [3:0]               tx_anum,
    output logic                     tx_data_ready,
    output logic [2:0]               err_flags
);

    localparam int RX = 0;
    localparam int TX = 1;

    sched_state_t             state_reg;
    logic                     job_valid_reg;
    logic                     job_dir_reg;
    logic [SLOT_W-1:0]        job_slot_reg;
    logic [ADDRESS_WIDTH-1:0] job_addr_reg;
    logic                     prio_tx_reg;
    logic [CNT_W-1:0]         fetch_pend_reg;
    logic [CNT_W-1:0]         fetch_pend_next;
    logic [ERR_W-1:0]         err_reg;
    logic [ERR_W-1:0]         err_next;

    logic idle, load_base, rx_elig, tx_elig, grant_rx, grant_tx;
    logic done_ok, rx_fill_ok, tx_drain_ok;

    logic [1:0]               ring_adv;
    logic [1:0]               ring_free_inc;
    logic [1:0]               ring_free_dec;
    logic [1:0]               ring_aux_inc;
    logic [1:0]               ring_aux_dec;
    logic [1:0]               ring_nz;
    logic [ADDRESS_WIDTH-1:0] ring_base [2];
    logic [ADDRESS_WIDTH-1:0] ring_addr [2];
    logic [SLOT_W-1:0]        ring_ptr  [2];
    logic [CNT_W-1:0]         ring_free [2];

    assign ring_base[RX] = cfg_rx_base;
    assign ring_base[TX] = cfg_tx_base;

    // RX ring: aux counts filled slots awaiting drain. TX ring: aux counts
    // fetched slots awaiting the host.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ring
            xfer_slot_ring u_ring (
                .clock_host  (clock_host),
                .reset       (reset),
                .load_base   (load_base),
                .cfg_base    (ring_base[gi]),
                .advance     (ring_adv[gi]),
                .free_inc    (ring_free_inc[gi]),
                .free_dec    (ring_free_dec[gi]),
                .aux_inc     (ring_aux_inc[gi]),
                .aux_dec     (ring_aux_dec[gi]),
                .ptr         (ring_ptr[gi]),
                .addr        (ring_addr[gi]),
                .free_cnt    (ring_free[gi]),
                .aux_nonzero (ring_nz[gi])
            );
        end
    endgenerate

    always_comb begin
        idle        = (state_reg == ST_IDLE);
        load_base   = idle && !sched_enable;
        rx_elig     = sched_enable && ring_nz[RX];
        tx_elig     = sched_enable && (fetch_pend_reg != '0) && (ring_free[TX] != '0);
        grant_tx    = idle && tx_elig && (!rx_elig || prio_tx_reg);
        grant_rx    = idle && rx_elig && !grant_tx;
        done_ok     = (state_reg == ST_WAIT_DONE) && job_done;
        rx_fill_ok  = rx_slot_filled && (ring_free[RX] != '0);
        tx_drain_ok = tx_slot_drained && ring_nz[TX];

        ring_adv[RX]      = grant_rx;
        ring_free_dec[RX] = rx_fill_ok;
        ring_aux_inc[RX]  = rx_fill_ok;
        ring_aux_dec[RX]  = grant_rx;
        ring_free_inc[RX] = done_ok && (job_dir_reg == JOB_RX_DRAIN);

        ring_adv[TX]      = grant_tx;
        ring_free_dec[TX] = grant_tx;
        ring_free_inc[TX] = tx_drain_ok;
        ring_aux_dec[TX]  = tx_drain_ok;
        ring_aux_inc[TX]  = done_ok && (job_dir_reg == JOB_TX_FILL);

        fetch_pend_next = fetch_pend_reg;
        if (tx_fetch_req && !grant_tx) begin
            if (fetch_pend_reg != CNT_W'(FETCH_MAX)) begin
                fetch_pend_next = fetch_pend_reg + CNT_W'(1);
            end
        end else if (!tx_fetch_req && grant_tx) begin
            fetch_pend_next = fetch_pend_reg - CNT_W'(1);
        end

        err_next = err_reg;
        if (rx_slot_filled && (ring_free[RX] == '0)) err_next[ERR_RX_OVF] = 1'b1;
        if (tx_slot_drained && !ring_nz[TX])         err_next[ERR_TX_UNF] = 1'b1;
        if (job_done && (state_reg != ST_WAIT_DONE)) err_next[ERR_SPUR_DONE] = 1'b1;
    end

    always_ff @(posedge clock_host or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            job_valid_reg  <= 1'b0;
            job_dir_reg    <= JOB_RX_DRAIN;
            job_slot_reg   <= '0;
            job_addr_reg   <= '0;
            prio_tx_reg    <= 1'b0;
            fetch_pend_reg <= '0;
            err_reg        <= '0;
        end else begin
            fetch_pend_reg <= fetch_pend_next;
            err_reg        <= err_next;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_rx || grant_tx) begin
                        job_valid_reg <= 1'b1;
                        job_dir_reg   <= grant_tx ? JOB_TX_FILL : JOB_RX_DRAIN;
                        job_slot_reg  <= grant_tx ? ring_ptr[TX] : ring_ptr[RX];
                        job_addr_reg  <= grant_tx ? ring_addr[TX] : ring_addr[RX];
                        prio_tx_reg   <= grant_rx;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (job_ready) begin
                        job_valid_reg <= 1'b0;
                        state_reg     <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (job_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign job_valid     = job_valid_reg;
    assign job_dir       = job_dir_reg;
    assign job_slot      = job_slot_reg;
    assign job_addr      = job_addr_reg;
    assign rx_anum       = ring_free[RX];
    assign tx_anum       = ring_free[TX];
    assign tx_data_ready = ring_nz[TX];
    assign err_flags     = err_reg;

endmodule

// File: tb/tb_xfer_slot_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a counter-level model of the slot scheduler.
module tb_xfer_slot_scheduler;
    import xfer_buf_pkg::*;

    localparam int DEPTH = MAX_BUFQ_DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] cfg_rx, cfg_tx;
    logic        rx_fill, tx_drain, tx_fetch, job_ready, job_done;
    logic        job_valid, job_dir, tx_data_ready;
    logic [2:0]  job_slot, err_flags;
    logic [31:0] job_addr;
    logic [3:0]  rx_anum, tx_anum;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;
    bit auto_eng = 0;
    bit rand_eng = 0;

    // Model state: plain counts, pointers and a two-flag job lifecycle.
    int          m_rx_anum, m_rx_pend, m_tx_anum, m_tx_avail, m_fetch, m_rx_ptr, m_tx_ptr, m_slot;
    logic [31:0] m_rx_addr, m_tx_addr, m_addr;
    bit          m_offered, m_busy, m_dir, m_last_dir;
    bit [2:0]    m_err;
    bit          log_dir [$];
    int          log_slot [$];
    logic [31:0] log_addr [$];

    always #5 clk = ~clk;

    xfer_slot_scheduler dut (
        .clock_host      (clk),
        .reset           (rst),
        .sched_enable    (en),
        .cfg_rx_base     (cfg_rx),
        .cfg_tx_base     (cfg_tx),
        .rx_slot_filled  (rx_fill),
        .tx_slot_drained (tx_drain),
        .tx_fetch_req    (tx_fetch),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_dir         (job_dir),
        .job_slot        (job_slot),
        .job_addr        (job_addr),
        .job_done        (job_done),
        .rx_anum         (rx_anum),
        .tx_anum         (tx_anum),
        .tx_data_ready   (tx_data_ready),
        .err_flags       (err_flags)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rx_anum = DEPTH; m_tx_anum = DEPTH;
        m_rx_pend = 0; m_tx_avail = 0; m_fetch = 0;
        m_rx_ptr = 0; m_tx_ptr = 0; m_slot = 0;
        m_rx_addr = cfg_rx; m_tx_addr = cfg_tx; m_addr = '0;
        m_offered = 0; m_busy = 0; m_dir = 0; m_last_dir = 1'b1;
        m_err = '0;
        log_dir.delete(); log_slot.delete(); log_addr.delete();
    endtask

    // One clock edge worth of rules, all read from pre-edge values and summed.
    task automatic model_step();
        bit idle, rx_ok, tx_ok, g_rx, g_tx;
        int d_rxa, d_rxp, d_txa, d_txv, d_f;
        d_rxa = 0; d_rxp = 0; d_txa = 0; d_txv = 0; d_f = 0;
        idle  = !m_offered && !m_busy;
        rx_ok = en && (m_rx_pend > 0);
        tx_ok = en && (m_fetch > 0) && (m_tx_anum > 0);
        g_tx  = idle && tx_ok && (!rx_ok || m_last_dir == 1'b0);
        g_rx  = idle && rx_ok && !g_tx;
        if (rx_fill) begin
            if (m_rx_anum == 0) m_err[0] = 1'b1;
            else begin d_rxa--; d_rxp++; end
        end
        if (tx_drain) begin
            if (m_tx_avail == 0) m_err[1] = 1'b1;
            else begin d_txv--; d_txa++; end
        end
        if (tx_fetch) d_f++;
        if (job_done) begin
            if (m_busy) begin
                if (m_dir) d_txv++; else d_rxa++;
                m_busy = 0;
            end else m_err[2] = 1'b1;
        end
        if (m_offered && job_ready) begin m_offered = 0; m_busy = 1; end
        if (g_rx) begin
            d_rxp--; m_dir = 0; m_slot = m_rx_ptr; m_addr = m_rx_addr;
            m_rx_ptr = (m_rx_ptr + 1) % DEPTH; m_rx_addr += SLOT_BYTES;
        end
        if (g_tx) begin
            d_f--; d_txa--; m_dir = 1; m_slot = m_tx_ptr; m_addr = m_tx_addr;
            m_tx_ptr = (m_tx_ptr + 1) % DEPTH; m_tx_addr += SLOT_BYTES;
        end
        if (g_rx || g_tx) begin
            m_offered = 1; m_last_dir = g_tx;
            log_dir.push_back(m_dir); log_slot.push_back(m_slot); log_addr.push_back(m_addr);
        end
        if (idle && !en) begin m_rx_addr = cfg_rx; m_tx_addr = cfg_tx; end
        m_rx_anum += d_rxa; m_rx_pend += d_rxp; m_tx_anum += d_txa; m_tx_avail += d_txv;
        m_fetch = (m_fetch + d_f > 15) ? 15 : m_fetch + d_f;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("job_valid", 64'(job_valid), 64'(m_offered));
            if (m_offered) begin
                chk("job_dir", 64'(job_dir), 64'(m_dir));
                chk("job_slot", 64'(job_slot), 64'(m_slot));
                chk("job_addr", 64'(job_addr), 64'(m_addr));
            end
            chk("rx_anum", 64'(rx_anum), 64'(m_rx_anum));
            chk("tx_anum", 64'(tx_anum), 64'(m_tx_anum));
            chk("tx_data_ready", 64'(tx_data_ready), 64'(m_tx_avail != 0));
            chk("err_flags", 64'(err_flags), 64'(m_err));
        end
    end

    // Returns two time units after the edge with host pulses cleared.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #2;
        rx_fill = 0; tx_drain = 0; tx_fetch = 0;
        if (auto_eng) begin
            job_ready = 1; job_done = m_busy;
        end else if (rand_eng) begin
            job_ready = ($urandom_range(0, 1) == 1);
            job_done  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
        end else begin
            job_done = 0;
        end
    endtask

    task automatic pulse(input bit f, input bit d, input bit q);
        rx_fill = f; tx_drain = d; tx_fetch = q;
        tick();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1; job_done = 0;
        model_reset();
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; en = 0; cfg_rx = 32'h1000_0000; cfg_tx = 32'h2000_0000;
        rx_fill = 0; tx_drain = 0; tx_fetch = 0; job_ready = 0; job_done = 0;
        model_reset();
        @(posedge clk); #2;
        chk("reset_rx_anum", 64'(rx_anum), 64'(4));
        chk("reset_tx_anum", 64'(tx_anum), 64'(4));
        chk("reset_job_valid", 64'(job_valid), 64'(0));
        chk("reset_job_slot", 64'(job_slot), 64'(0));
        chk("reset_job_addr", 64'(job_addr), 64'(0));
        chk("reset_err", 64'(err_flags), 64'(0));
        chk("reset_tx_ready", 64'(tx_data_ready), 64'(0));
        tick();
        rst = 0;
        chk_en = 1;

        // Single RX job, engine always ready.
        do_reset(); en = 1; job_ready = 1;
        pulse(1, 0, 0);
        chk("s1_rx_anum_fill", 64'(rx_anum), 64'(3));
        chk("s1_valid_not_yet", 64'(job_valid), 64'(0));
        tick();
        chk("s1_valid", 64'(job_valid), 64'(1));
        chk("s1_dir", 64'(job_dir), 64'(0));
        chk("s1_slot", 64'(job_slot), 64'(0));
        chk("s1_addr", 64'(job_addr), 64'(32'h1000_0000));
        tick();
        chk("s1_valid_drop", 64'(job_valid), 64'(0));
        job_done = 1; tick();
        chk("s1_rx_anum_back", 64'(rx_anum), 64'(4));

        // RX overflow.
        do_reset(); en = 1; job_ready = 0;
        for (int i = 0; i < 5; i++) begin
            pulse(1, 0, 0);
            if (i == 3) chk("s2_rx_anum_zero", 64'(rx_anum), 64'(0));
        end
        chk("s2_rx_anum_stays", 64'(rx_anum), 64'(0));
        chk("s2_err_ovf", 64'(err_flags), 64'(3'b001));

        // Round-robin alternation.
        do_reset(); en = 1; auto_eng = 1;
        pulse(1, 0, 1); pulse(1, 0, 1); run(20);
        chk("s3_jobs", 64'(log_dir.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk("s3_dir", 64'(log_dir[i]), 64'(i % 2));
        chk("s3_slot1", 64'(log_slot[1]), 64'(0));
        chk("s3_slot3", 64'(log_slot[3]), 64'(1));
        chk("s3_rx_addr2", 64'(log_addr[2]), 64'(32'h1000_1000));
        chk("s3_tx_addr1", 64'(log_addr[1]), 64'(32'h2000_0000));
        chk("s3_tx_addr3", 64'(log_addr[3]), 64'(32'h2000_1000));
        chk("s3_tx_anum", 64'(tx_anum), 64'(2));
        chk("s3_tx_ready", 64'(tx_data_ready), 64'(1));

        // Slot pointer wrap over six RX jobs.
        do_reset(); en = 1; auto_eng = 1;
        for (int i = 0; i < 6; i++) begin pulse(1, 0, 0); run(4); end
        chk("s4_jobs", 64'(log_slot.size()), 64'(6));
        for (int i = 0; i < 6; i++) chk("s4_slot", 64'(log_slot[i]), 64'(i % 4));
        chk("s4_addr5", 64'(log_addr[5]), 64'(32'h1000_5000));

        // TX fetch limited by free slots, then underflow.
        do_reset(); en = 1; auto_eng = 1;
        repeat (5) pulse(0, 0, 1);
        run(30);
        chk("s5_jobs4", 64'(log_slot.size()), 64'(4));
        chk("s5_tx_anum0", 64'(tx_anum), 64'(0));
        chk("s5_tx_ready", 64'(tx_data_ready), 64'(1));
        pulse(0, 1, 0); run(10);
        chk("s5_jobs5", 64'(log_slot.size()), 64'(5));
        chk("s5_slot_wrap", 64'(log_slot[4]), 64'(0));
        repeat (4) pulse(0, 1, 0);
        chk("s5_no_err", 64'(err_flags), 64'(0));
        pulse(0, 1, 0);
        chk("s5_err_unf", 64'(err_flags), 64'(3'b010));
        chk("s5_tx_anum4", 64'(tx_anum), 64'(4));

        // Reset while a job is offered.
        do_reset(); en = 1; auto_eng = 0; job_ready = 0;
        pulse(1, 0, 0); tick();
        chk("s6_valid_before", 64'(job_valid), 64'(1));
        rst = 1; model_reset();
        #1;
        chk("s6_valid_async_drop", 64'(job_valid), 64'(0));
        chk("s6_rx_anum", 64'(rx_anum), 64'(4));
        tick(); tick();
        rst = 0;
        job_done = 1; tick();
        chk("s6_err_spur", 64'(err_flags), 64'(3'b100));

        // Randomized traffic.
        do_reset(); rand_eng = 1; cfg_tx = 32'hFFFF_E000;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                en = ($urandom_range(0, 9) != 0);
                if (!en && $urandom_range(0, 1) == 1) begin
                    cfg_rx = $urandom; cfg_tx = $urandom;
                end
                rx_fill  = ($urandom_range(0, 3) == 0);
                tx_drain = ($urandom_range(0, 3) == 0);
                tx_fetch = ($urandom_range(0, 3) == 0);
                tick();
            end
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/xfer_slot_scheduler.md
Name: xfer_slot_scheduler

Overview:
Bottom-half sequencer for the host transfer buffer's RX and TX slot rings. Each ring holds MAX_BUFQ_DEPTH slots of UNIT_BUF_BY_4B words.
- Tracks slot occupancy from host-side completion pulses.
- Arbitrates round-robin between RX drain jobs (buffer to TBM) and TX fill jobs (TBM to buffer).
- Issues one job at a time, with slot index and TBM address, to the memory-transfer engine.
- Publishes the rx_anum/tx_anum free-slot counts that feed the gs_out status path.

Parameters:
MAX_BUFQ_DEPTH, 4, slots per ring (power of two, 2..8)
UNIT_BUF_BY_4B, 1024, 32-bit words per slot
ADDRESS_WIDTH, 32, TBM address width
SLOT_BYTES, UNIT_BUF_BY_4B*4, address stride per job

Ports:
clock_host  in  1  sole clock
reset  in  1  asynchronous, active-high
sched_enable  in  1  1 = grants allowed; 0 = idle and base-address load
cfg_rx_base  in  ADDRESS_WIDTH  RX TBM base, loaded while sched_enable=0
cfg_tx_base  in  ADDRESS_WIDTH  TX TBM base, loaded while sched_enable=0
rx_slot_filled  in  1  pulse: host finished writing one RX slot
tx_slot_drained  in  1  pulse: host finished reading one TX slot
tx_fetch_req  in  1  pulse: request one TX slot fill from TBM
job_valid  out  1  job offered
job_ready  in  1  engine accepts job
job_dir  out  1  0 = RX drain, 1 = TX fill
job_slot  out  3  slot index
job_addr  out  ADDRESS_WIDTH  TBM byte address
job_done  in  1  pulse: accepted job finished
rx_anum  out  4  free RX slots
tx_anum  out  4  free TX slots
tx_data_ready  out  1  at least one filled TX slot awaits host
err_flags  out  3  sticky: [0] RX overflow, [1] TX underflow, [2] spurious job_done

Behaviour:
- Reset values:
  - rx_anum = tx_anum = MAX_BUFQ_DEPTH.
  - job_valid = 0; job_dir = 0; job_slot = 0; job_addr = 0; tx_data_ready = 0; err_flags = 0.
  - All pointers, rx_pend, tx_avail and fetch_pend = 0; address counters = cfg bases; state IDLE; RR priority = RX.
- Reset asserted mid-job drops job_valid immediately; the in-flight job is abandoned.
- RX accounting:
  - rx_slot_filled: if rx_anum==0, set err[0] and ignore; else rx_anum-1 and rx_pend+1.
  - RX grant: rx_pend-1; job_slot = rx_drain_ptr; then the pointer increments, wrapping at DEPTH-1 to 0.
  - RX job_done: rx_anum+1.
- TX accounting:
  - tx_fetch_req: fetch_pend+1, saturating at 15.
  - TX grant: fetch_pend-1, tx_anum-1 (slot reserved); job_slot = tx_fill_ptr; then the pointer increments with wrap.
  - TX job_done: tx_avail+1.
  - tx_slot_drained: if tx_avail==0, set err[1] and ignore; else tx_avail-1 and tx_anum+1.
  - tx_data_ready = (tx_avail != 0), registered.
- Eligibility:
  - RX eligible = rx_pend != 0.
  - TX eligible = fetch_pend != 0 and tx_anum != 0.
  - Both require sched_enable=1.
- Arbitration: round-robin. Once both requesters are eligible, the one not granted last wins. A single eligible requester wins regardless.
- Addresses:
  - RX grant uses rx_addr, then rx_addr += SLOT_BYTES. TX grant likewise uses tx_addr.
  - Both wrap modulo 2^ADDRESS_WIDTH.
  - While sched_enable=0 and the FSM is IDLE, rx_addr = cfg_rx_base and tx_addr = cfg_tx_base.
- FSM:
  - IDLE: if any requester is eligible, grant at this edge (counters updated), drive job_* and set job_valid=1, go to ISSUE.
  - ISSUE: hold job_* stable while job_valid=1. When job_ready=1, drop job_valid next edge and go to WAIT_DONE.
  - WAIT_DONE: on job_done, apply completion accounting and go to IDLE.
  - Deasserting sched_enable in ISSUE or WAIT_DONE does not cancel; the job completes.
  - job_done in IDLE or ISSUE sets err[2] and is otherwise ignored.
- Latency:
  - A host pulse registered at edge E makes the requester eligible after E.
  - job_valid rises at edge E+1 at the earliest.
  - After job_done at edge D, the next job_valid can rise at D+1.
- Simultaneous events all apply in the same cycle; net count changes are summed. Examples:
  - rx_slot_filled with RX job_done: rx_anum unchanged.
  - tx_slot_drained with TX grant: tx_anum unchanged.
  - Overflow/underflow checks use pre-cycle values.
- Counters never exceed DEPTH or go below 0 by construction; guarded events are the only entry points.

Decomposition:
- Package xfer_buf_pkg holds:
  - MAX_BUFQ_DEPTH, UNIT_BUF_BY_4B, SLOT_BYTES, HDATA_WIDTH, ADDRESS_WIDTH.
  - Job-direction constants JOB_RX_DRAIN=0, JOB_TX_FILL=1.
  - FSM state encodings and err_flags bit indices.
- One sub-module, xfer_slot_ring: wrap-around pointer, free/pending counters and address counter, instantiated once for RX and once for TX. The FSM and arbiter stay in the top.

Test Plan:
- Reset, enable, 1 rx_slot_filled, job_ready tied 1:
  - rx_anum goes to 3.
  - job_valid rises 1 clock after the pulse, with dir=0, slot=0, addr=cfg_rx_base.
  - job_done brings rx_anum back to 4.
- 5 rx_slot_filled pulses, job_ready=0: rx_anum reaches 0 after 4; the 5th sets err[0]; rx_anum stays 0.
- RX and TX both eligible, 4 jobs completed:
  - Directions alternate RX, TX, RX, TX.
  - TX addresses are cfg_tx_base and cfg_tx_base+0x1000.
  - Slot indices increment 0, 1.
- 6 RX jobs with DEPTH=4: job_slot sequence is 0,1,2,3,0,1.
- tx_fetch_req x5 with no drains:
  - Exactly 4 TX jobs issue; tx_anum reaches 0 and tx_data_ready=1.
  - One tx_slot_drained lets the 5th job issue.
  - Draining with tx_avail=0 sets err[1].
- Assert reset during ISSUE: job_valid drops immediately; all counters return to reset values; a later job_done sets err[2].
